// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_ITERS = 32;
    localparam int MULDIV_CNT_W = $clog2(MULDIV_ITERS);

    typedef enum logic [2:0] {
        MULDIV_MULT  = 3'd0,
        MULDIV_MULTU = 3'd1,
        MULDIV_DIV   = 3'd2,
        MULDIV_DIVU  = 3'd3,
        MULDIV_MTHI  = 3'd4,
        MULDIV_MTLO  = 3'd5
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_abs.sv
// Combinational conditional two's-complement negate: magnitude of a signed
// operand, or re-signing of an unsigned result.
module muldiv_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// The divider is only built when MULDIV_DIV_EN is defined; otherwise DIV/DIVU report div_by_zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_e           r_state, w_next;
    muldiv_op_e              r_op;
    logic [MULDIV_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0]      r_acc;
    logic [WIDTH-1:0]        r_opb, r_hi, r_lo;
    logic                    r_neg, r_dbz, r_done, r_dbz_out;

    logic w_is_mul, w_is_div, w_is_mt, w_signed, w_dbz, w_accept, w_last;
    logic [1:0][WIDTH-1:0] w_opnd, w_mag;
    logic [1:0]            w_opneg;
    logic [WIDTH:0]        w_mul_sum;
    logic [2*WIDTH-1:0]    w_prod;

    assign w_is_mul = (op == MULDIV_MULT) || (op == MULDIV_MULTU);
    assign w_is_div = (op == MULDIV_DIV)  || (op == MULDIV_DIVU);
    assign w_is_mt  = (op == MULDIV_MTHI) || (op == MULDIV_MTLO);
    assign w_signed = (op == MULDIV_MULT) || (op == MULDIV_DIV);
    assign w_accept = (r_state == ST_IDLE) && start && (w_is_mul || w_is_div || w_is_mt);
    assign w_last   = (r_cnt == MULDIV_CNT_W'(MULDIV_ITERS - 1));
`ifdef MULDIV_DIV_EN
    assign w_dbz    = w_is_div && (b == '0);
`else
    assign w_dbz    = w_is_div;
`endif

    // Signed ops iterate on magnitudes; the sign is re-applied in FIN.
    assign w_opnd  = {b, a};
    assign w_opneg = {w_signed & b[WIDTH-1], w_signed & a[WIDTH-1]};

    for (genvar g = 0; g < 2; g++) begin : g_abs_op
        muldiv_abs #(.W(WIDTH)) u_abs_op (
            .i_val (w_opnd[g]),
            .i_neg (w_opneg[g]),
            .o_val (w_mag[g])
        );
    end

    muldiv_abs #(.W(2*WIDTH)) u_abs_res (
        .i_val (r_acc),
        .i_neg (r_neg),
        .o_val (w_prod)
    );

    // acc = {partial product, remaining multiplier bits}, shifted right each step
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : '0)};

`ifdef MULDIV_DIV_EN
    // acc = {remainder, dividend/quotient}, shifted left each step
    logic                  r_neg_rem;
    logic [WIDTH:0]        w_div_sh, w_div_diff;
    logic [2*WIDTH-1:0]    w_div_acc;
    logic [WIDTH-1:0]      w_quot, w_rem;

    assign w_div_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = w_div_sh - {1'b0, r_opb};
    assign w_div_acc  = w_div_diff[WIDTH] ? {w_div_sh[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b0}
                                          : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_quot     = r_neg     ? (~r_acc[WIDTH-1:0] + WIDTH'(1))       : r_acc[WIDTH-1:0];
    assign w_rem      = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_neg_rem <= 1'b0;
        else if (w_accept) r_neg_rem <= w_opneg[0];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul)             w_next = ST_MUL;
`ifdef MULDIV_DIV_EN
                    else if (w_is_div && !w_dbz) w_next = ST_DIV;
`endif
                    else                      w_next = ST_FIN;
                end
            end
            ST_MUL:  if (w_last) w_next = ST_FIN;
`ifdef MULDIV_DIV_EN
            ST_DIV:  if (w_last) w_next = ST_FIN;
`endif
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op      <= MULDIV_MULT;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_neg     <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= muldiv_op_e'(op);
                        r_acc <= {{WIDTH{1'b0}}, w_mag[0]};
                        r_opb <= w_mag[1];
                        r_neg <= w_opneg[0] ^ w_opneg[1];
                        r_dbz <= w_dbz;
                        r_cnt <= '0;
                    end
                end
                ST_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= w_last ? '0 : r_cnt + MULDIV_CNT_W'(1);
                end
`ifdef MULDIV_DIV_EN
                ST_DIV: begin
                    r_acc <= w_div_acc;
                    r_cnt <= w_last ? '0 : r_cnt + MULDIV_CNT_W'(1);
                end
`endif
                ST_FIN: begin
                    r_done    <= 1'b1;
                    r_dbz_out <= r_dbz;
                    case (r_op)
                        MULDIV_MULT, MULDIV_MULTU: {r_hi, r_lo} <= w_prod;
`ifdef MULDIV_DIV_EN
                        MULDIV_DIV, MULDIV_DIVU: begin
                            if (!r_dbz) begin
                                r_hi <= w_rem;
                                r_lo <= w_quot;
                            end
                        end
`endif
                        MULDIV_MTHI: r_hi <= r_acc[WIDTH-1:0];
                        MULDIV_MTLO: r_lo <= r_acc[WIDTH-1:0];
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz_out;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural result of one request; lat = edges from acceptance to done (0 = ignored op).
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el,
                         output bit edbz, output int lat);
        longint sx, sy, q, r;
        logic [63:0] p;
        eh = m_hi; el = m_lo; edbz = 0; lat = 1;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = sx * sy; {eh, el} = p; lat = 33; end
            3'd1: begin p = {32'b0, x} * {32'b0, y}; {eh, el} = p; lat = 33; end
            3'd2, 3'd3: begin
`ifdef MULDIV_DIV_EN
                if (y != 0) begin
                    lat = 33;
                    if (o == 3'd2) begin
                        q = sx / sy; r = sx % sy;
                        el = q[31:0]; eh = r[31:0];
                    end else begin
                        el = x / y; eh = x % y;
                    end
                end else edbz = 1;
`else
                edbz = 1;
`endif
            end
            3'd4: eh = x;
            3'd5: el = x;
            default: lat = 0;
        endcase
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit noise);
        logic [31:0] eh, el;
        bit edbz;
        int lat, n, busy_cnt, hold_bad;
        model(o, x, y, eh, el, edbz, lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        chk("done_pulse_end", done, 0);
        if (lat == 0) begin
            repeat (3) begin
                chk("rsv_busy", busy, 0);
                chk("rsv_done", done, 0);
                @(posedge clk); #1;
            end
            chk("rsv_hi", hi, m_hi);
            chk("rsv_lo", lo, m_lo);
            return;
        end
        chk("busy_accept", busy, 1);
        n = 0; busy_cnt = 0; hold_bad = 0;
        while (!done && n < 45) begin
            if (busy) busy_cnt++;
            if (hi !== m_hi || lo !== m_lo) hold_bad++;
            start = (noise && n < lat) ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("latency", n, lat);
        chk("busy_cycles", busy_cnt, lat);
        chk("hold", hold_bad, 0);
        chk("busy_at_done", busy, 0);
        chk("dbz", div_by_zero, edbz);
        chk("hi", hi, eh);
        chk("lo", lo, el);
        m_hi = eh; m_lo = el;
    endtask

    initial begin
        int nd;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clk) reset_n = 1'b1;

        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd3, 32'd100, 32'd7, 0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd4, 32'h11, 32'h0, 0);
        do_op(3'd5, 32'h22, 32'h0, 0);
        do_op(3'd3, 32'd5, 32'd0, 0);
        do_op(3'd2, 32'hDEAD_BEEF, 32'd0, 0);
        do_op(3'd4, 32'h1234_5678, 32'h0, 0);
        do_op(3'd6, 32'hAAAA_AAAA, 32'h5, 0);
        do_op(3'd7, 32'h5555_5555, 32'h3, 0);
        do_op(3'd1, 32'hCAFE_0001, 32'h0000_1234, 1);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 16));
                default: ;
            endcase
            do_op(ro, ra, rb, 1'($urandom));
        end

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'h0001_0003; b = 32'h0000_0777;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_busy", busy, 0);
        m_hi = '0; m_lo = '0;
        @(negedge clk) reset_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("midrst_no_done", nd, 0);
        do_op(3'd1, 32'd3, 32'd4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
